// File: rtl/pulse_gen_detect.sv
// Ultrasonic ranging front end: repeating WAIT -> TRIG -> MEAS -> UPDATE frames that
// count echo-high cycles and raise a sticky flag on an exact target echo width.
module pulse_gen_detect #(
    parameter int WAIT_CYCLES   = 50,
    parameter int TRIG_CYCLES   = 500,
    parameter int MEAS_CYCLES   = 50000,
    parameter int TARGET_PULSES = 29410
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        echo_rx,
    output logic        trigger,
    output logic        out,
    output logic [21:0] pulses,
    output logic [1:0]  state
);

    localparam int CNT_W = 22;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [21:0]      TARGET    = 22'(TARGET_PULSES);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_TRIG   = 2'd1,
        S_MEAS   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] phase_cnt;

    // phase_cnt counts cycles spent in the current state; it restarts on every transition.
    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state_q   <= S_WAIT;
            phase_cnt <= '0;
            trigger   <= 1'b0;
            out       <= 1'b0;
            pulses    <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (phase_cnt == WAIT_LAST) begin
                        state_q   <= S_TRIG;
                        trigger   <= 1'b1;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_TRIG: begin
                    if (phase_cnt == TRIG_LAST) begin
                        state_q   <= S_MEAS;
                        trigger   <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_MEAS: begin
                    // Window length bounds the count, so the 22-bit counter never wraps.
                    if (echo_rx)
                        pulses <= pulses + 22'd1;
                    if (phase_cnt == MEAS_LAST) begin
                        state_q   <= S_UPDATE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (pulses == TARGET)
                        out <= 1'b1;
                    pulses    <= '0;
                    phase_cnt <= '0;
                    state_q   <= S_WAIT;
                end
                default: begin
                    state_q   <= S_WAIT;
                    phase_cnt <= '0;
                    trigger   <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pulse_gen_detect.sv
// Bench for pulse_gen_detect: a scaled-down instance for frame-level scenarios and a
// full-size instance running one real frame in parallel.
module tb_pulse_gen_detect;

    // Scaled instance: WAIT 5, TRIG 10, MEAS 100, target 59 -> frame of 116 cycles.
    localparam int S_WAIT_C = 5;
    localparam int S_TRIG_C = 10;
    localparam int S_MEAS_C = 100;
    localparam int S_TGT_C  = 59;

    logic        clk_50M = 1'b0;
    logic        reset_s, echo_s;
    logic        trigger_s, out_s;
    logic [21:0] pulses_s;
    logic [1:0]  state_s;

    logic        reset_l, echo_l;
    logic        trigger_l, out_l;
    logic [21:0] pulses_l;
    logic [1:0]  state_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk_50M = ~clk_50M;

    pulse_gen_detect #(
        .WAIT_CYCLES  (S_WAIT_C),
        .TRIG_CYCLES  (S_TRIG_C),
        .MEAS_CYCLES  (S_MEAS_C),
        .TARGET_PULSES(S_TGT_C)
    ) u_dut_s (
        .clk_50M(clk_50M),
        .reset  (reset_s),
        .echo_rx(echo_s),
        .trigger(trigger_s),
        .out    (out_s),
        .pulses (pulses_s),
        .state  (state_s)
    );

    pulse_gen_detect u_dut_l (
        .clk_50M(clk_50M),
        .reset  (reset_l),
        .echo_rx(echo_l),
        .trigger(trigger_l),
        .out    (out_l),
        .pulses (pulses_l),
        .state  (state_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check_zero_s(input string tag);
        check_eq({tag, "_state"},   32'(state_s),   32'd0);
        check_eq({tag, "_trigger"}, 32'(trigger_s), 32'd0);
        check_eq({tag, "_out"},     32'(out_s),     32'd0);
        check_eq({tag, "_pulses"},  32'(pulses_s),  32'd0);
    endtask

    // Starts with the scaled DUT freshly in WAIT (phase 0) and ends just after the
    // UPDATE->WAIT edge. MEAS samples echo on edges 16..115 after frame start, so
    // MEAS slot j (1..100) is edge 15+j. Echo high in slots [1,w1] and
    // [w1+gap+1, w1+gap+w2]; noise also drives echo high outside MEAS.
    task automatic run_frame(input string tag, input int w1, input int gap, input int w2,
                             input bit noise, input bit chk_seq, input int exp_p,
                             input bit out_prev, input bit out_next);
        for (int e = 1; e <= 116; e++) begin
            int j;
            int es;
            j = e - 15;
            echo_s = (noise && (e <= 15 || e >= 116)) ||
                     (j >= 1 && j <= w1) ||
                     (j > w1 + gap && j <= w1 + gap + w2);
            tick();
            if (e < 5)        es = 0;
            else if (e < 15)  es = 1;
            else if (e < 115) es = 2;
            else if (e == 115) es = 3;
            else              es = 0;
            if (chk_seq) begin
                check_eq({tag, "_seq_state"},   32'(state_s),   32'(es));
                check_eq({tag, "_seq_trigger"}, 32'(trigger_s), (es == 1) ? 32'd1 : 32'd0);
            end
            if (e == 114)
                check_eq({tag, "_out_in_meas"}, 32'(out_s), 32'(out_prev));
            if (e == 115) begin
                check_eq({tag, "_upd_state"},  32'(state_s),  32'd3);
                check_eq({tag, "_upd_pulses"}, 32'(pulses_s), 32'(exp_p));
                check_eq({tag, "_upd_out"},    32'(out_s),    32'(out_prev));
            end
            if (e == 116) begin
                check_eq({tag, "_end_state"},  32'(state_s),  32'd0);
                check_eq({tag, "_end_pulses"}, 32'(pulses_s), 32'd0);
                check_eq({tag, "_end_out"},    32'(out_s),    32'(out_next));
            end
        end
        echo_s = 1'b0;
    endtask

    task automatic small_seq();
        reset_s = 1'b0;
        echo_s  = 1'b0;
        repeat (3) tick();
        check_zero_s("por");
        reset_s = 1'b1;

        run_frame("f_294us", 29, 0, 0, 1'b0, 1'b1, 29, 1'b0, 1'b0);
        run_frame("f_target", 59, 0, 0, 1'b0, 1'b0, 59, 1'b0, 1'b1);
        run_frame("f_980us", 98, 0, 0, 1'b0, 1'b0, 98, 1'b1, 1'b1);
        run_frame("f_sticky", 29, 0, 0, 1'b0, 1'b0, 29, 1'b1, 1'b1);

        // Reset in the middle of MEAS with echo high and out already set.
        echo_s = 1'b1;
        repeat (50) tick();
        check_eq("mid_pre_state", 32'(state_s), 32'd2);
        check_eq("mid_pre_out",   32'(out_s),   32'd1);
        reset_s = 1'b0;
        #2;
        check_zero_s("mid_async");
        tick();
        check_zero_s("mid_hold");
        echo_s  = 1'b0;
        reset_s = 1'b1;
        run_frame("f_after_rst", 59, 0, 0, 1'b0, 1'b1, 59, 1'b0, 1'b1);

        reset_s = 1'b0;
        tick();
        check_zero_s("rst2");
        reset_s = 1'b1;
        run_frame("f_minus1", 58, 0, 0, 1'b1, 1'b0, 58, 1'b0, 1'b0);
        run_frame("f_plus1", 60, 0, 0, 1'b0, 1'b0, 60, 1'b0, 1'b0);
        run_frame("f_full", 100, 0, 0, 1'b1, 1'b0, 100, 1'b0, 1'b0);
        run_frame("f_two_bursts", 30, 10, 29, 1'b0, 1'b0, 59, 1'b0, 1'b1);
    endtask

    // Full-size frame: trigger on edges 50..549, MEAS samples edges 551..50550,
    // UPDATE after edge 50550, out set by edge 50551, next trigger at edge 50601.
    task automatic large_seq();
        reset_l = 1'b0;
        echo_l  = 1'b0;
        repeat (3) tick();
        check_eq("l_por_trigger", 32'(trigger_l), 32'd0);
        reset_l = 1'b1;
        for (int e = 1; e <= 50601; e++) begin
            echo_l = (e >= 551 && e <= 29960);
            tick();
            case (e)
                49: check_eq("l_trig_pre", 32'(trigger_l), 32'd0);
                50: begin
                    check_eq("l_trig_rise",  32'(trigger_l), 32'd1);
                    check_eq("l_state_trig", 32'(state_l),   32'd1);
                end
                549: check_eq("l_trig_hold", 32'(trigger_l), 32'd1);
                550: begin
                    check_eq("l_trig_fall",  32'(trigger_l), 32'd0);
                    check_eq("l_state_meas", 32'(state_l),   32'd2);
                end
                50550: begin
                    check_eq("l_upd_state",  32'(state_l),  32'd3);
                    check_eq("l_upd_pulses", 32'(pulses_l), 32'd29410);
                    check_eq("l_upd_out",    32'(out_l),    32'd0);
                end
                50551: begin
                    check_eq("l_out_set",    32'(out_l),    32'd1);
                    check_eq("l_end_state",  32'(state_l),  32'd0);
                    check_eq("l_end_pulses", 32'(pulses_l), 32'd0);
                end
                50600: check_eq("l_trig2_pre",  32'(trigger_l), 32'd0);
                50601: check_eq("l_trig2_rise", 32'(trigger_l), 32'd1);
                default: ;
            endcase
        end
        echo_l = 1'b0;
    endtask

    initial begin
        reset_s = 1'b0;
        reset_l = 1'b0;
        echo_s  = 1'b0;
        echo_l  = 1'b0;
        #1;
        fork
            small_seq();
            large_seq();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
